// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3MType_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdState_e;

  function automatic logic rs1_signed(funct3MType_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic rs2_signed(funct3MType_e op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// UNROLL chained iterations on {acc, opr}: shift-add multiply or restoring divide.
module riscv_muldiv_step #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opr,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_acc,
  output logic [XLEN-1:0] next_opr
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] o;
  logic [XLEN:0]   t;

  always_comb begin
    a = acc;
    o = opr;
    t = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (div) begin
        // Remainder shifts in the next dividend bit; quotient bits fill opr from the bottom.
        t = {a, o[XLEN-1]};
        o = {o[XLEN-2:0], 1'b0};
        if (t >= {1'b0, operand}) begin
          t    = t - {1'b0, operand};
          o[0] = 1'b1;
        end
        a = t[XLEN-1:0];
      end else begin
        // Product {acc, opr} shifts right; multiplier bits leave opr from the bottom.
        t = {1'b0, a} + (o[0] ? {1'b0, operand} : '0);
        o = {t[0], o[XLEN-1:1]};
        a = t[XLEN:1];
      end
    end
    next_acc = a;
    next_opr = o;
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshake, flush and backpressure.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  localparam int unsigned K  = XLEN / UNROLL;
  localparam int unsigned CW = $clog2(K + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdState_e        state;
  funct3MType_e    op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, opr, operand, result_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic [XLEN-1:0] next_acc, next_opr;

  funct3MType_e    op_in;
  logic            is_div, sign1, sign2, neg_in, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag1, mag2, special_res, fix_res;
  logic [2*XLEN-1:0] prod_s;

  assign op_in    = funct3MType_e'(op_i);
  assign is_div   = op_i[2];
  assign sign1    = rs1_signed(op_in) & rs1_i[XLEN-1];
  assign sign2    = rs2_signed(op_in) & rs2_i[XLEN-1];
  assign mag1     = sign1 ? (~rs1_i + 1'b1) : rs1_i;
  assign mag2     = sign2 ? (~rs2_i + 1'b1) : rs2_i;
  assign neg_in   = (is_div & op_i[1]) ? sign1 : (sign1 ^ sign2);
  assign div_zero = (rs2_i == '0);
  assign div_ovf  = !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
  assign special  = is_div & (div_zero | div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else          special_res = op_i[1] ? '0 : rs1_i;
  end

  assign in_ready_o  = ((state == IDLE) | ((state == DONE) & out_ready_i)) & !flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

  riscv_muldiv_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_step (
    .div      (op_q[2]),
    .acc      (acc),
    .opr      (opr),
    .operand  (operand),
    .next_acc (next_acc),
    .next_opr (next_opr)
  );

  // One sign flag covers every op: it was chosen per-op at accept time.
  assign prod_s = neg_q ? (~{acc, opr} + 1'b1) : {acc, opr};

  always_comb begin
    fix_res = '0;
    case (op_q)
      MUL:                 fix_res = prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_res = neg_q ? (~opr + 1'b1) : opr;
      default:             fix_res = neg_q ? (~acc + 1'b1) : acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= MUL;
      cnt      <= '0;
      acc      <= '0;
      opr      <= '0;
      operand  <= '0;
      result_q <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_i;
            neg_q <= neg_in;
            if (special) begin
              result_q <= special_res;
              state    <= DONE;
            end else begin
              acc     <= '0;
              opr     <= is_div ? mag1 : mag2;
              operand <= is_div ? mag2 : mag1;
              cnt     <= CW'(K);
              state   <= CALC;
            end
          end else if (state == DONE && out_ready_i) begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= next_acc;
          opr <= next_opr;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          state    <= DONE;
        end
      endcase
    end
  end

endmodule
